hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Control end of the EX-stage forwarding path. Tracks destination and source registers of in-flight instructions through the ID/EX, EX/MEM and MEM/WB stages.
- Drives the 2-bit operand-select codes consumed by the two EX-stage forwarding muxes.
- Detects load-use hazards and asserts a one-cycle stall that inserts a bubble.
- Keeps a saturating count of inserted load-use bubbles for performance inspection.

Parameters:
REG_AW, 5, architectural register index width
CNT_W, 32, width of load-use stall counter

Ports:
clk_i  input  1  core clock
rst_i  input  1  asynchronous reset, active-high
id_valid_i  input  1  ID stage holds a valid instruction
id_rs1_i  input  REG_AW  ID source register 1
id_rs2_i  input  REG_AW  ID source register 2
id_rs1_used_i  input  1  instruction reads rs1
id_rs2_used_i  input  1  instruction reads rs2
id_rd_i  input  REG_AW  ID destination register
id_regwrite_i  input  1  instruction writes rd
id_memread_i  input  1  instruction is a load
flush_i  input  1  ID instruction is wrong-path (taken branch/jump); squash it
hold_i  input  1  global pipeline freeze (memory wait)
fwd_a_o  output  2  select for EX operand A: 00 register file, 01 MEM/WB, 10 EX/MEM
fwd_b_o  output  2  select for EX operand B, same encoding
stall_o  output  1  load-use hazard: hold PC and IF/ID, bubble into ID/EX
stall_cnt_o  output  CNT_W  number of load-use bubbles inserted

Behaviour:
- Three tracking entries: E (ID/EX), M (EX/MEM), W (MEM/WB).
  - All entries hold: valid, rd, regwrite, memread.
  - E additionally holds: rs1, rs2, rs1_used, rs2_used.
- Reset (async, rst_i=1): all entry fields 0, stall_cnt_o=0; hence fwd_a_o=fwd_b_o=00 and stall_o=0 while in reset.
- Clock edge with hold_i=0:
  - W<=M; M<=E.
  - E<=bubble (valid=0, all fields 0) if stall_o | flush_i | !id_valid_i; otherwise E<=ID inputs with valid=1.
- Clock edge with hold_i=1: all entries and the counter hold their values.
- stall_o (combinational) = id_valid_i & !flush_i & E.valid & E.memread & E.rd!=0 & ((id_rs1_used_i & id_rs1_i==E.rd) | (id_rs2_used_i & id_rs2_i==E.rd)).
  - stall_o is still computed while hold_i=1; it takes effect on the first unheld edge.
- fwd_a_o (combinational, from registered state only):
  - 10 if E.valid & E.rs1_used & E.rs1!=0 & M.valid & M.regwrite & M.rd==E.rs1.
  - else 01 if the same condition holds against W.
  - else 00.
  - fwd_b_o: identical, using rs2.
- EX/MEM priority over MEM/WB when both match: the youngest producer wins.
- x0 is never forwarded and never causes a stall.
- A matching M entry with memread=1 must never occur (prevented by the load-use stall); the bench asserts this.
- The register file is write-before-read, so W retires after one cycle with no ID-stage bypass.
- Simultaneous flush_i and load-use hazard: flush wins, stall_o=0, bubble inserted, counter unchanged.
- stall_cnt_o increments on each edge where stall_o=1 and hold_i=0; it saturates at all-ones (no wrap).
- Load-use latency: exactly one bubble per hazard. The dependent instruction enters E on the next unheld edge and sees fwd=01 from the load in W.
- Reset mid-operation: all in-flight entries are discarded immediately. Outputs return to 00/0 combinationally with rst_i; the counter clears.

Decomposition:
- Shared package: FWD_REGFILE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10; packed struct for a pipe entry (valid, rd, regwrite, memread); REG_AW constant.
- Sub-module fwd_select: combinational comparator taking source index, used flag and the M and W entries, and returning the 2-bit code. Instantiated twice (A and B).

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 back-to-back -> cycle sub is in E: fwd_a_o=10, fwd_b_o=00.
- add x5 then nop then or x7,x4,x5 -> fwd_b_o=01 when or is in E.
- add x5 then addi x5 then and x8,x5,x5 -> fwd_a_o=fwd_b_o=10 (M beats W).
- lw x6,0(x1) then add x7,x6,x2 -> stall_o=1 for exactly one cycle, E bubble, then fwd_a_o=01; stall_cnt_o=1.
- Write to x0 followed by a read of x0, and lw x0 then a use of x0 -> fwd=00, stall_o=0.
- Load-use hazard with flush_i=1 -> no stall, count stays 0. Load-use with hold_i=1 for 3 cycles -> entries frozen, count increments once after release. Assert rst_i mid-stream -> outputs 00/0 and count 0 immediately.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl_pkg
// Description : Shared forwarding-select codes and pipeline tracking entry.
// Revision    : 1.0
// ============================================================================
package hazard_forward_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM_WB  = 2'b01;
    localparam logic [1:0] FWD_EX_MEM  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } pipe_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_select
// Description : Operand-select comparator for one EX-stage forwarding mux.
// Revision    : 1.0
// ============================================================================
module fwd_select
    import hazard_forward_ctrl_pkg::*;
(
    input  logic              i_e_valid,
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_src_used,
    input  pipe_entry_t       i_m_entry,
    input  pipe_entry_t       i_w_entry,
    output logic [1:0]        o_sel
);

    logic w_src_live;
    logic w_m_hit;
    logic w_w_hit;

    // x0 is hardwired zero, so a read of it never needs a bypass
    assign w_src_live = i_e_valid & i_src_used & (i_src != '0);
    assign w_m_hit    = w_src_live & i_m_entry.valid & i_m_entry.regwrite & (i_m_entry.rd == i_src);
    assign w_w_hit    = w_src_live & i_w_entry.valid & i_w_entry.regwrite & (i_w_entry.rd == i_src);

    // The younger producer in EX/MEM overrides the older one in MEM/WB
    assign o_sel = w_m_hit ? FWD_EX_MEM :
                   w_w_hit ? FWD_MEM_WB : FWD_REGFILE;

endmodule
`default_nettype wire

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : EX-stage forwarding select, load-use stall and stall counter.
// Revision    : 1.0
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    import hazard_forward_ctrl_pkg::*;

    pipe_entry_t       r_e;
    logic [REG_AW-1:0] r_e_rs1;
    logic [REG_AW-1:0] r_e_rs2;
    logic              r_e_rs1_used;
    logic              r_e_rs2_used;
    pipe_entry_t       r_m;
    pipe_entry_t       r_w;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_stall;
    logic              w_insert_bubble;

    assign w_rs1_hit = id_rs1_used_i & (id_rs1_i == r_e.rd);
    assign w_rs2_hit = id_rs2_used_i & (id_rs2_i == r_e.rd);

    // A squashed ID instruction cannot be a consumer, so flush masks the stall
    assign w_stall = id_valid_i & ~flush_i & r_e.valid & r_e.memread &
                     (r_e.rd != '0) & (w_rs1_hit | w_rs2_hit);

    assign w_insert_bubble = w_stall | flush_i | ~id_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_e          <= '0;
            r_e_rs1      <= '0;
            r_e_rs2      <= '0;
            r_e_rs1_used <= 1'b0;
            r_e_rs2_used <= 1'b0;
            r_m          <= '0;
            r_w          <= '0;
            r_stall_cnt  <= '0;
        end else if (!hold_i) begin
            r_w <= r_m;
            r_m <= r_e;
            if (w_insert_bubble) begin
                r_e          <= '0;
                r_e_rs1      <= '0;
                r_e_rs2      <= '0;
                r_e_rs1_used <= 1'b0;
                r_e_rs2_used <= 1'b0;
            end else begin
                r_e.valid    <= 1'b1;
                r_e.rd       <= id_rd_i;
                r_e.regwrite <= id_regwrite_i;
                r_e.memread  <= id_memread_i;
                r_e_rs1      <= id_rs1_i;
                r_e_rs2      <= id_rs2_i;
                r_e_rs1_used <= id_rs1_used_i;
                r_e_rs2_used <= id_rs2_used_i;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    fwd_select u_fwd_a (
        .i_e_valid  (r_e.valid),
        .i_src      (r_e_rs1),
        .i_src_used (r_e_rs1_used),
        .i_m_entry  (r_m),
        .i_w_entry  (r_w),
        .o_sel      (fwd_a_o)
    );

    fwd_select u_fwd_b (
        .i_e_valid  (r_e.valid),
        .i_src      (r_e_rs2),
        .i_src_used (r_e_rs2_used),
        .i_m_entry  (r_m),
        .i_w_entry  (r_w),
        .o_sel      (fwd_b_o)
    );

    assign stall_o     = w_stall;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Directed and randomized checks of hazard_forward_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          id_valid_i = 1'b0;
    logic [AW-1:0] id_rs1_i = '0;
    logic [AW-1:0] id_rs2_i = '0;
    logic          id_rs1_used_i = 1'b0;
    logic          id_rs2_used_i = 1'b0;
    logic [AW-1:0] id_rd_i = '0;
    logic          id_regwrite_i = 1'b0;
    logic          id_memread_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          hold_i = 1'b0;
    logic [1:0]    fwd_a_o;
    logic [1:0]    fwd_b_o;
    logic          stall_o;
    logic [CW-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // Reference model: in-flight instructions, index 0 is youngest (ID/EX)
    typedef struct {
        bit valid;
        int rd, rs1, rs2;
        bit u1, u2, rw, mr;
    } instr_t;

    instr_t pipe [3];
    int     m_cnt = 0;
    bit     m_st;

    function automatic bit model_stall();
        if (!id_valid_i || flush_i || !pipe[0].valid || !pipe[0].mr || pipe[0].rd == 0)
            return 1'b0;
        return (id_rs1_used_i && int'(id_rs1_i) == pipe[0].rd) ||
               (id_rs2_used_i && int'(id_rs2_i) == pipe[0].rd);
    endfunction

    function automatic logic [1:0] model_fwd(input int src, input bit used);
        if (!pipe[0].valid || !used || src == 0) return 2'b00;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].valid && pipe[k].rw && pipe[k].rd == src)
                return (k == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
            m_cnt = 0;
        end else if (!hold_i) begin
            m_st = model_stall();
            if (m_st && m_cnt < (1 << CW) - 1) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (m_st || flush_i || !id_valid_i)
                pipe[0] = '{default: 0};
            else
                pipe[0] = '{valid: 1'b1, rd: int'(id_rd_i), rs1: int'(id_rs1_i),
                            rs2: int'(id_rs2_i), u1: id_rs1_used_i, u2: id_rs2_used_i,
                            rw: id_regwrite_i, mr: id_memread_i};
        end
    end

    task automatic drive_id(input int rs1, input bit u1, input int rs2, input bit u2,
                            input int rd, input bit rw, input bit mr);
        id_valid_i    = 1'b1;
        id_rs1_i      = AW'(rs1);
        id_rs1_used_i = u1;
        id_rs2_i      = AW'(rs2);
        id_rs2_used_i = u2;
        id_rd_i       = AW'(rd);
        id_regwrite_i = rw;
        id_memread_i  = mr;
    endtask

    task automatic clear_id();
        id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rs1_used_i = 1'b0;
        id_rs2_used_i = 1'b0; id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit mr);
        drive_id(rs1, u1, rs2, u2, rd, rw, mr);
        tick();
        clear_id();
    endtask

    task automatic do_reset();
        clear_id(); flush_i = 1'b0; hold_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_id(); flush_i = 1'b0; hold_i = 1'b0; rst_i = 1'b1;
        tick(); tick();
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b expected 00", fwd_b_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
        checks++; if (stall_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_ex_mem_fwd();
        do_reset();
        issue(1, 1, 2, 1, 5, 1, 0);          // add x5,x1,x2
        issue(5, 1, 3, 1, 6, 1, 0);          // sub x6,x5,x3
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL exmem_fwd_a: got %b expected 10", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL exmem_fwd_b: got %b expected 00", fwd_b_o); end
    endtask

    task automatic test_mem_wb_fwd();
        do_reset();
        issue(1, 1, 2, 1, 5, 1, 0);          // add x5
        tick();                              // nop
        issue(4, 1, 5, 1, 7, 1, 0);          // or x7,x4,x5
        checks++; if (fwd_b_o !== 2'b01) begin errors++; $display("FAIL memwb_fwd_b: got %b expected 01", fwd_b_o); end
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL memwb_fwd_a: got %b expected 00", fwd_a_o); end
    endtask

    task automatic test_priority();
        do_reset();
        issue(1, 1, 2, 1, 5, 1, 0);          // add x5
        issue(5, 1, 0, 0, 5, 1, 0);          // addi x5,x5,imm
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL prio_addi_fwd_a: got %b expected 10", fwd_a_o); end
        issue(5, 1, 5, 1, 8, 1, 0);          // and x8,x5,x5
        checks++; if (fwd_a_o !== 2'b10) begin errors++; $display("FAIL prio_fwd_a: got %b expected 10", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b10) begin errors++; $display("FAIL prio_fwd_b: got %b expected 10", fwd_b_o); end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 1, 0, 0, 6, 1, 1);          // lw x6,0(x1)
        drive_id(6, 1, 2, 1, 7, 1, 0);       // add x7,x6,x2
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", stall_o); end
        tick();
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_stall_once: got %b expected 0", stall_o); end
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL lu_bubble_fwd_a: got %b expected 00", fwd_a_o); end
        checks++; if (stall_cnt_o !== CW'(1)) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt_o); end
        tick();
        clear_id();
        checks++; if (fwd_a_o !== 2'b01) begin errors++; $display("FAIL lu_fwd_a: got %b expected 01", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b expected 00", fwd_b_o); end
        checks++; if (stall_cnt_o !== CW'(1)) begin errors++; $display("FAIL lu_cnt_after: got %0d expected 1", stall_cnt_o); end
    endtask

    task automatic test_x0();
        do_reset();
        issue(1, 1, 2, 1, 0, 1, 0);          // add x0,x1,x2
        issue(0, 1, 0, 1, 9, 1, 0);          // reads x0
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL x0_fwd_a: got %b expected 00", fwd_a_o); end
        checks++; if (fwd_b_o !== 2'b00) begin errors++; $display("FAIL x0_fwd_b: got %b expected 00", fwd_b_o); end
        issue(1, 1, 0, 0, 0, 1, 1);          // lw x0
        drive_id(0, 1, 0, 1, 10, 1, 0);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b expected 0", stall_o); end
        tick();
        clear_id();
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL x0_lw_fwd_a: got %b expected 00", fwd_a_o); end
        checks++; if (stall_cnt_o !== '0) begin errors++; $display("FAIL x0_cnt: got %0d expected 0", stall_cnt_o); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(1, 1, 0, 0, 6, 1, 1);          // lw x6
        drive_id(6, 1, 2, 1, 7, 1, 0);
        flush_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
        tick();
        flush_i = 1'b0;
        clear_id();
        checks++; if (stall_cnt_o !== '0) begin errors++; $display("FAIL flush_cnt: got %0d expected 0", stall_cnt_o); end
        tick();
        checks++; if (fwd_a_o !== 2'b00) begin errors++; $display("FAIL flush_fwd_a: got %b expected 00", fwd_a_o); end
    endtask

    task automatic test_hold();
        do_reset();
        issue(1, 1, 0, 0, 6, 1, 1);          // lw x6
        drive_id(6, 1, 2, 1, 7, 1, 0);
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall_o); end
            checks++; if (stall_cnt_o !== '0) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d expected 0", i, stall_cnt_o); end
        end
        hold_i = 1'b0;
        tick();
        checks++; if (stall_cnt_o !== CW'(1)) begin errors++; $display("FAIL hold_release_cnt: got %0d expected 1", stall_cnt_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %b expected 0", stall_o); end
        tick();
        clear_id();
        checks++; if (fwd_a_o !== 2'b01) begin errors++; $display("FAIL hold_fwd_a: got %b expected 01", fwd_a_o); end
    endtask

    task automatic test_reset_mid();
        issue(2, 1, 0, 0, 4, 1, 1);          // lw x4, count already nonzero
        drive_id(4, 1, 4, 1, 11, 1, 0);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_stall: got %b expected 1", stall_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rmid_stall: got %b expected 0", stall_o); end
        checks++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin errors++; $display("FAIL rmid_fwd: got %b/%b expected 00/00", fwd_a_o, fwd_b_o); end
        checks++; if (stall_cnt_o !== '0) begin errors++; $display("FAIL rmid_cnt: got %0d expected 0", stall_cnt_o); end
        tick();
        rst_i = 1'b0;
        clear_id();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk_i);
            #1;
            id_valid_i    = ($urandom_range(3) != 0);
            id_rs1_i      = AW'($urandom_range(3));
            id_rs2_i      = AW'($urandom_range(3));
            id_rs1_used_i = 1'($urandom_range(1));
            id_rs2_used_i = 1'($urandom_range(1));
            id_rd_i       = AW'($urandom_range(3));
            id_regwrite_i = ($urandom_range(3) != 0);
            id_memread_i  = ($urandom_range(2) == 0);
            flush_i       = ($urandom_range(7) == 0);
            hold_i        = ($urandom_range(7) == 0);
            @(negedge clk_i);
            checks++; if (fwd_a_o !== model_fwd(pipe[0].rs1, pipe[0].u1)) begin errors++; $display("FAIL rnd_fwd_a cyc %0d: got %b expected %b", cyc, fwd_a_o, model_fwd(pipe[0].rs1, pipe[0].u1)); end
            checks++; if (fwd_b_o !== model_fwd(pipe[0].rs2, pipe[0].u2)) begin errors++; $display("FAIL rnd_fwd_b cyc %0d: got %b expected %b", cyc, fwd_b_o, model_fwd(pipe[0].rs2, pipe[0].u2)); end
            checks++; if (stall_o !== model_stall()) begin errors++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", cyc, stall_o, model_stall()); end
            checks++; if (int'(stall_cnt_o) != m_cnt) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d expected %0d", cyc, stall_cnt_o, m_cnt); end
            // A load sitting in EX/MEM must never be the producer for the E operand
            checks++;
            if (dut.r_e.valid && dut.r_m.valid && dut.r_m.memread && dut.r_m.rd != '0 &&
                ((dut.r_e_rs1_used && dut.r_e_rs1 == dut.r_m.rd) ||
                 (dut.r_e_rs2_used && dut.r_e_rs2 == dut.r_m.rd))) begin
                errors++; $display("FAIL rnd_load_in_mem cyc %0d: got load producer in EX/MEM expected none", cyc);
            end
        end
        checks++; if (m_cnt != (1 << CW) - 1 || stall_cnt_o !== '1) begin errors++; $display("FAIL rnd_saturate: got %0d expected %0d", stall_cnt_o, (1 << CW) - 1); end
        hold_i = 1'b0; flush_i = 1'b0; clear_id();
    endtask

    initial begin
        test_reset();
        test_ex_mem_fwd();
        test_mem_wb_fwd();
        test_priority();
        test_load_use();
        test_x0();
        test_flush();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
